// File: rtl/riscv_pkg.sv
// Shared fetch-sequencer definitions: FSM state encoding, instruction size, default vectors.
package riscv_pkg;

    typedef enum logic [2:0] {
        FS_IDLE   = 3'd0,
        FS_REQ    = 3'd1,
        FS_WAIT   = 3'd2,
        FS_HOLD   = 3'd3,
        FS_HALTED = 3'd4
    } fetch_state_e;

    localparam int unsigned INST_BYTES       = 4;
    localparam logic [31:0] RESET_VECTOR_DEF = 32'h0000_0000;
    localparam logic [31:0] TRAP_VECTOR_DEF  = 32'h0000_0100;

endpackage

// File: rtl/pc_target_sel.sv
// Next-PC select (trap > redirect > sequential > hold) with misaligned-redirect detection.
// Purely combinational, no backpressure.
module pc_target_sel
    import riscv_pkg::*;
#(
    parameter int unsigned      Width      = 32,
    parameter logic [Width-1:0] TrapVector = TRAP_VECTOR_DEF[Width-1:0]
) (
    input  logic [Width-1:0] pc_i,
    input  logic             advance_i,
    input  logic             trap_valid_i,
    input  logic             redirect_valid_i,
    input  logic [Width-1:0] redirect_target_i,
    output logic             redir_o,
    output logic             misalign_o,
    output logic [Width-1:0] next_pc_o
);

    assign misalign_o = redirect_valid_i && !trap_valid_i && (redirect_target_i[1:0] != 2'b00);
    assign redir_o    = trap_valid_i || redirect_valid_i;

    always_comb begin
        if (trap_valid_i || misalign_o) begin
            next_pc_o = TrapVector;
        end else if (redirect_valid_i) begin
            next_pc_o = redirect_target_i;
        end else if (advance_i) begin
            next_pc_o = pc_i + Width'(INST_BYTES);
        end else begin
            next_pc_o = pc_i;
        end
    end

endmodule

// File: rtl/pc_fetch_sequencer.sv
// PC owner and single-outstanding imem fetch FSM with a one-entry decode buffer.
// First request one cycle after reset release; stalls on imem_req_ready / inst_ready.
module pc_fetch_sequencer
    import riscv_pkg::*;
#(
    parameter int unsigned      Width       = 32,
    parameter logic [Width-1:0] ResetVector = RESET_VECTOR_DEF[Width-1:0],
    parameter logic [Width-1:0] TrapVector  = TRAP_VECTOR_DEF[Width-1:0]
) (
    input  logic             clk,
    input  logic             rstn,
    output logic             imem_req_valid,
    input  logic             imem_req_ready,
    output logic [Width-1:0] imem_req_addr,
    input  logic             imem_rsp_valid,
    input  logic [31:0]      imem_rsp_data,
    output logic             inst_valid,
    input  logic             inst_ready,
    output logic [31:0]      inst_data,
    output logic [Width-1:0] inst_pc,
    input  logic             redirect_valid,
    input  logic [Width-1:0] redirect_target,
    input  logic             trap_valid,
    input  logic             halt,
    output logic [Width-1:0] pc_out,
    output logic             misaligned_err
);

    fetch_state_e     state_q, state_d;
    logic [Width-1:0] pc_q, pc_d;
    logic             drop_q, drop_d;
    logic             iv_q, iv_d;
    logic [31:0]      idat_q, idat_d;
    logic [Width-1:0] ipc_q, ipc_d;
    logic             mis_q, mis_d;

    logic             advance;
    logic             redir;
    logic             misalign;
    logic [Width-1:0] next_pc;

    assign advance = (state_q == FS_HOLD) && inst_ready;

    pc_target_sel #(
        .Width      (Width),
        .TrapVector (TrapVector)
    ) u_target_sel (
        .pc_i              (pc_q),
        .advance_i         (advance),
        .trap_valid_i      (trap_valid),
        .redirect_valid_i  (redirect_valid),
        .redirect_target_i (redirect_target),
        .redir_o           (redir),
        .misalign_o        (misalign),
        .next_pc_o         (next_pc)
    );

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        drop_d  = drop_q;
        iv_d    = iv_q;
        idat_d  = idat_q;
        ipc_d   = ipc_q;
        mis_d   = 1'b0;
        if (state_q != FS_IDLE) begin
            pc_d  = next_pc;
            mis_d = misalign;
        end
        case (state_q)
            FS_IDLE: state_d = FS_REQ;
            FS_REQ: begin
                // A redirect racing the handshake poisons the response already in flight.
                if (imem_req_ready) begin
                    state_d = FS_WAIT;
                    drop_d  = redir;
                end
            end
            FS_WAIT: begin
                if (imem_rsp_valid) begin
                    if (redir || drop_q) begin
                        drop_d  = 1'b0;
                        state_d = FS_REQ;
                    end else begin
                        idat_d  = imem_rsp_data;
                        ipc_d   = pc_q;
                        iv_d    = 1'b1;
                        state_d = FS_HOLD;
                    end
                end else if (redir) begin
                    drop_d = 1'b1;
                end
            end
            FS_HOLD: begin
                if (redir) begin
                    iv_d    = 1'b0;
                    state_d = FS_REQ;
                end else if (inst_ready) begin
                    iv_d    = 1'b0;
                    state_d = halt ? FS_HALTED : FS_REQ;
                end
            end
            FS_HALTED: begin
                if (!halt) state_d = FS_REQ;
            end
            default: state_d = FS_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= FS_IDLE;
            pc_q    <= ResetVector;
            drop_q  <= 1'b0;
            iv_q    <= 1'b0;
            idat_q  <= '0;
            ipc_q   <= '0;
            mis_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            drop_q  <= drop_d;
            iv_q    <= iv_d;
            idat_q  <= idat_d;
            ipc_q   <= ipc_d;
            mis_q   <= mis_d;
        end
    end

    assign imem_req_valid = (state_q == FS_REQ);
    assign imem_req_addr  = pc_q;
    assign pc_out         = pc_q;
    assign inst_valid     = iv_q;
    assign inst_data      = idat_q;
    assign inst_pc        = ipc_q;
    assign misaligned_err = mis_q;

endmodule

// File: doc/pc_fetch_sequencer.md
Name: pc_fetch_sequencer

Overview:
- Controls the program-counter datapath of the single-cycle RISC-V core once instruction memory gains a multi-cycle handshake.
- Owns the PC register and issues one instruction fetch at a time to imem over a valid/ready request and a valid response.
- Buffers the fetched word for decode.
- Applies redirects from branch/jump/trap logic with priority trap > redirect > sequential, and drops stale in-flight responses.

Parameters:
Width, 32, instruction address width
ResetVector, 32'h0000_0000, PC value after reset
TrapVector, 32'h0000_0100, PC loaded on trap or misaligned redirect

Ports:
clk  in  1  clock, rising edge
rstn  in  1  reset, asynchronous, active-low
imem_req_valid  out  1  fetch request valid
imem_req_ready  in  1  imem accepts request
imem_req_addr  out  Width  fetch address (equals pc_out)
imem_rsp_valid  in  1  fetch data returned, single-cycle pulse
imem_rsp_data  in  32  fetched instruction word
inst_valid  out  1  buffered instruction available to decode
inst_ready  in  1  decode accepts instruction
inst_data  out  32  buffered instruction
inst_pc  out  Width  address of inst_data
redirect_valid  in  1  branch/jump taken this cycle
redirect_target  in  Width  new PC
trap_valid  in  1  exception/interrupt, go to TrapVector
halt  in  1  stop fetching after the current instruction is accepted
pc_out  out  Width  current PC register
misaligned_err  out  1  one-cycle pulse when redirect_target[1:0] != 0

Behaviour:
- Reset (rstn low, asynchronous): state=IDLE, pc=ResetVector, drop=0, inst_valid=0, inst_data=0, inst_pc=0, imem_req_valid=0, misaligned_err=0. All outputs are registered or decoded from state only.
- States: IDLE, REQ, WAIT, HOLD, HALTED.
- IDLE: lasts exactly one cycle after rstn rises, then REQ. First imem_req_valid=1 occurs on cycle 1 after deassertion. rsp_valid in IDLE is ignored.
- REQ: imem_req_valid=1, addr=pc.
  - On req_valid&&req_ready, go to WAIT.
  - Redirect while ready=0: pc updates and the request stays valid with the new address next cycle. Retargeting is permitted by the imem contract.
- WAIT: req_valid=0.
  - On rsp_valid with drop=0: inst_data<=rsp_data, inst_pc<=pc, inst_valid<=1, go to HOLD.
  - On rsp_valid with drop=1: discard the word, clear drop, go to REQ.
- HOLD: inst_valid=1.
  - On inst_valid&&inst_ready: pc<=pc+4 (wraps modulo 2^Width) and inst_valid<=0.
  - Next state after acceptance: HALTED if halt=1, else REQ.
- HALTED: req_valid=0. Go to REQ on the first cycle halt=0.
- Redirect/trap, evaluated every non-IDLE cycle:
  - Effective target is TrapVector if trap_valid, else redirect_target.
  - If redirect_valid && redirect_target[1:0]!=0 and trap_valid=0: target=TrapVector and misaligned_err pulses 1 the next cycle.
  - pc<=target in all cases.
  - REQ with no handshake this cycle: stay in REQ.
  - REQ with handshake this cycle: go to WAIT with drop<=1.
  - WAIT with no rsp this cycle: drop<=1, stay in WAIT.
  - WAIT with rsp this cycle: discard the word, go to REQ.
  - HOLD: inst_valid<=0, go to REQ. Redirect wins even if inst_ready=1 the same cycle; pc is not incremented and decode flushes.
  - HALTED: pc updated, state unchanged.
- Halt does not abort an in-flight request; it is sampled only at HOLD acceptance and in HALTED.
- Exactly one request is outstanding at a time. Response ordering is guaranteed by imem.

Decomposition:
- Shared package riscv_pkg holds:
  - fetch-state enum (IDLE, REQ, WAIT, HOLD, HALTED), 3 bits
  - constant INST_BYTES=4
  - default vector constants
- One natural sub-module: pc_target_sel, combinational. It selects trap/redirect/sequential target and flags misalignment. The PC register and FSM stay in the top.

Test Plan:
- Release reset, imem ready=1, rsp 1 cycle after accept, inst_ready=1 -> req addrs 0x0,0x4,0x8; inst_pc matches; first req_valid on cycle 1.
- Assert rstn low mid-WAIT, then release -> all outputs zero immediately, pc=0x0, and a rsp_valid arriving in IDLE is ignored.
- Redirect to 0x40 during WAIT, rsp arrives 2 cycles later with 0xDEADBEEF -> word discarded, inst_valid stays 0, next req addr 0x40.
- Redirect to 0x42 in HOLD -> pc=TrapVector 0x100, misaligned_err pulses one cycle, held inst dropped.
- trap_valid and redirect_valid (0x80) in the same cycle in REQ with ready=0 -> req_addr becomes 0x100 next cycle, req_valid stays 1.
- halt=1 at HOLD acceptance of pc 0x8 -> HALTED, no req; halt=0 -> req addr 0xC. Start pc near 0xFFFFFFFC -> wraps to 0x0.
